// File: rtl/mult_ctrl_if.sv
// Bundle of request, MTHI/MTLO write, architectural result and external multiplier
// signals around mult_ctrl; slave = controller side, master = environment side.
interface mult_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        mul_ready;

  modport slave (
    input  req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data,
           mul_hi, mul_lo, mul_ready,
    output req_ready, hi, lo, busy, done, mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data,
           mul_hi, mul_lo, mul_ready,
    input  req_ready, hi, lo, busy, done, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mult_ctrl.sv
// MULT/MULTU sequencer in front of an unsigned iterative multiplier, owning HI/LO.
// Define MULT_CTRL_SIGNED_EN to enable sign-magnitude handling of MULT requests.
module mult_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  mult_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;

  state_e      state_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] mul_a_q, mul_b_q;
  logic        done_q, mul_start_q;
  logic        first_q;
  logic [31:0] a_d, b_d;
  logic [63:0] prod, res_d;

  assign prod = {bus.mul_hi, bus.mul_lo};

`ifdef MULT_CTRL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitude of 0x80000000 wraps to itself, which is the right unsigned value.
  always_comb begin
    neg_d = bus.req_signed & (bus.req_a[31] ^ bus.req_b[31]);
    a_d   = (bus.req_signed & bus.req_a[31]) ? (~bus.req_a + 32'd1) : bus.req_a;
    b_d   = (bus.req_signed & bus.req_b[31]) ? (~bus.req_b + 32'd1) : bus.req_b;
    res_d = neg_q ? (~prod + 64'd1) : prod;
  end
`else
  logic unused_req_signed;

  assign unused_req_signed = bus.req_signed;

  always_comb begin
    a_d   = bus.req_a;
    b_d   = bus.req_b;
    res_d = prod;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      first_q     <= 1'b0;
`ifdef MULT_CTRL_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wr_data;
          if (bus.wr_lo) lo_q <= bus.wr_data;
          if (bus.req_valid) begin
            mul_a_q     <= a_d;
            mul_b_q     <= b_d;
`ifdef MULT_CTRL_SIGNED_EN
            neg_q       <= neg_d;
`endif
            mul_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          first_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          // mul_ready may still be high from the previous product on the first cycle.
          first_q <= 1'b0;
          if (!first_q && bus.mul_ready) begin
            {hi_q, lo_q} <= res_d;
            done_q       <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.done      = done_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a 32-iteration behavioural multiplier whose
// ready flag stays high after completion until one cycle past the next start.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic hang = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  mult_ctrl_if bus();

  mult_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 0;
      bus.mul_ready <= 1'b0;
      bus.mul_hi    <= '0;
      bus.mul_lo    <= '0;
    end else if (bus.mul_start) begin
      cnt <= 32;
    end else if (cnt != 0) begin
      if (cnt == 32) bus.mul_ready <= 1'b0;
      cnt <= cnt - 1;
      if (cnt == 1 && !hang) begin
        bus.mul_ready <= 1'b1;
        {bus.mul_hi, bus.mul_lo} <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk({tag, " mul_start one cycle"}, 64'(bus.mul_start), 64'd0);
    end while (!bus.done && n < 200);
    chk({tag, " latency"}, 64'(n), 64'd34);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ema, input logic [31:0] emb,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bus.req_valid  = 1'b1;
    bus.req_signed = sgn;
    bus.req_a      = a;
    bus.req_b      = b;
    chk({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    chk({tag, " mul_start"}, 64'(bus.mul_start), 64'd1);
    chk({tag, " mul_a"}, 64'(bus.mul_a), 64'(ema));
    chk({tag, " mul_b"}, 64'(bus.mul_b), 64'(emb));
    wait_done(tag);
    chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
    tick();
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int k;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.wr_hi      = 1'b0;
    bus.wr_lo      = 1'b0;
    bus.wr_data    = '0;
    repeat (2) tick();
    chk("rst hi", 64'(bus.hi), 64'd0);
    chk("rst lo", 64'(bus.lo), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst mul_start", 64'(bus.mul_start), 64'd0);
    chk("rst mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MTHI / MTLO in IDLE
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234_5678;
    tick();
    bus.wr_hi = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h1234_5678);
    bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFE_F00D;
    tick();
    bus.wr_lo = 1'b0;
    chk("mtlo", 64'(bus.lo), 64'hCAFE_F00D);
    chk("mtlo keeps hi", 64'(bus.hi), 64'h1234_5678);

    run_op("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001);
`ifdef MULT_CTRL_SIGNED_EN
    run_op("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'h7, 32'h3, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0);
    run_op("s_5xm1", 1'b1, 32'h5, 32'hFFFF_FFFF, 32'h5, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
`else
    run_op("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFD, 32'h7, 32'h6, 32'hFFFF_FFEB);
    run_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0);
    run_op("s_5xm1", 1'b1, 32'h5, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h4, 32'hFFFF_FFFB);
`endif

    // Back-to-back: second request held high through the first operation
    bus.req_valid = 1'b1; bus.req_signed = 1'b0; bus.req_a = 32'd2; bus.req_b = 32'd3;
    tick();
    bus.req_a = 32'd7; bus.req_b = 32'd9;
    chk("b2b ready low", 64'(bus.req_ready), 64'd0);
    tick();
    tick();
    bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.wr_lo = 1'b0;
    chk("mtlo while busy dropped", 64'(bus.lo), 64'hFFFF_FFFB);
    chk("b2b still busy", 64'(bus.busy), 64'd1);
    k = 0;
    while (!bus.done && k < 100) begin tick(); k++; end
    chk("b2b first done", 64'(bus.done), 64'd1);
    chk("b2b first lo", 64'(bus.lo), 64'd6);
    chk("b2b ready after done", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b second accepted", 64'(bus.mul_start), 64'd1);
    chk("b2b second mul_a", 64'(bus.mul_a), 64'd7);
    wait_done("b2b second");
    chk("b2b second hi", 64'(bus.hi), 64'd0);
    chk("b2b second lo", 64'(bus.lo), 64'd63);

    // Same-cycle request and MTHI: write lands, product later overwrites it
    tick();
    bus.req_valid = 1'b1; bus.req_a = 32'd1; bus.req_b = 32'd1;
    bus.wr_hi = 1'b1; bus.wr_data = 32'hAAAA_5555;
    tick();
    bus.req_valid = 1'b0; bus.wr_hi = 1'b0;
    chk("same-cycle mthi", 64'(bus.hi), 64'hAAAA_5555);
    wait_done("same-cycle");
    chk("same-cycle hi", 64'(bus.hi), 64'd0);
    chk("same-cycle lo", 64'(bus.lo), 64'd1);

    // Reset ten cycles into an operation
    tick();
    bus.req_valid = 1'b1; bus.req_a = 32'h0001_0000; bus.req_b = 32'h0001_0000;
    tick();
    bus.req_valid = 1'b0;
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("midrst hi", 64'(bus.hi), 64'd0);
    chk("midrst lo", 64'(bus.lo), 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst mul_a", 64'(bus.mul_a), 64'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (50) begin tick(); if (bus.done) k++; end
    chk("midrst no done", 64'(k), 64'd0);
    run_op("post-rst", 1'b0, 32'h0001_0000, 32'h0003_0000, 32'h0001_0000, 32'h0003_0000,
           32'h3, 32'h0);

    // Multiplier that never answers keeps the block waiting
    hang = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = 32'd5; bus.req_b = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    k = 0;
    repeat (80) begin tick(); if (bus.done) k++; end
    chk("hang no done", 64'(k), 64'd0);
    chk("hang busy", 64'(bus.busy), 64'd1);
    chk("hang lo kept", 64'(bus.lo), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("hang rst busy", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid  in  1  MULT/MULTU request; req_ready  out  1  high only in IDLE.
REQ-004 SHALL have ports: req_signed  in  1  1=MULT, 0=MULTU; req_a, req_b  in  32  operands.
REQ-005 SHALL have ports: wr_hi, wr_lo  in  1  MTHI/MTLO strobes; wr_data  in  32  write data.
REQ-006 SHALL have ports: hi, lo  out  32  architectural HI/LO registers; busy  out  1  state not IDLE; done  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: mul_start  out  1; mul_a, mul_b  out  32  unsigned operands; mul_hi, mul_lo  in  32  product; mul_ready  in  1  multiplier result valid.

Function
REQ-008 SHALL implement states IDLE, START, WAIT.
REQ-009 In IDLE with req_valid=1, SHALL capture operands at the clock edge and go to START; handshake = req_valid & req_ready.
REQ-010 For a signed request, SHALL load mul_a/mul_b with the two's-complement magnitude of each operand and record neg = req_a[31] ^ req_b[31]; for an unsigned request, SHALL pass operands unchanged with neg=0.
REQ-011 Magnitude of 0x80000000 SHALL be 0x80000000, interpreted as unsigned.
REQ-012 In START, SHALL assert mul_start for exactly one cycle, then go to WAIT.
REQ-013 mul_a/mul_b SHALL be held stable from START until return to IDLE.
REQ-014 In WAIT, SHALL ignore mul_ready in the first WAIT cycle, because mul_ready can be stale high from the previous operation.
REQ-015 On mul_ready=1 in any later WAIT cycle, SHALL load {hi,lo} with {mul_hi,mul_lo}, or its 64-bit two's-complement negation if neg=1, and assert done; next state SHALL be IDLE.
REQ-016 With a 32-iteration multiplier, done SHALL be high 34 cycles after the accepting edge.
REQ-017 wr_hi/wr_lo SHALL update hi/lo only in IDLE; writes while busy=1 SHALL be dropped.
REQ-018 A same-cycle request and write in IDLE SHALL apply both; the completing product SHALL overwrite the write.
REQ-019 done and mul_start SHALL be 0 in all cycles other than those stated above.
REQ-020 hi/lo SHALL hold their value between updates.
REQ-021 The block SHALL contain no timeout; a multiplier that never asserts mul_ready SHALL keep the block in WAIT.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE; hi=0, lo=0, done=0, mul_start=0, busy=0, neg=0, mul_a=0, mul_b=0.
REQ-023 Reset in the middle of an operation SHALL abandon it; no done pulse SHALL be produced, and the next request after release SHALL behave as if from power-up.

Configuration
REQ-024 Macro MULT_CTRL_SIGNED_EN defined: REQ-010/011 signed handling in force.
REQ-025 Macro MULT_CTRL_SIGNED_EN undefined: req_signed SHALL be ignored; all requests SHALL be treated as unsigned, and no negation logic SHALL be synthesised.

Verification
REQ-026 Unsigned request A=0xFFFFFFFF, B=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
REQ-027 Signed request A=0xFFFFFFFD (-3), B=0x00000007 (macro defined) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with the macro undefined -> hi=0x00000006, lo=0xFFFFFFEB.
REQ-028 Signed request A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-029 Two back-to-back requests, the second held high during the first -> req_ready=0 and the second not accepted until the cycle after done; second result correct; mul_ready stale high not treated as completion.
REQ-030 wr_hi=1 with wr_data=0x12345678 in IDLE -> hi=0x12345678.
REQ-031 wr_lo=1 while busy -> lo unchanged.
REQ-032 rst_n pulled low at cycle 10 of an operation -> hi=lo=0, busy=0 immediately, no done pulse.
REQ-033 Request after reset release -> correct product.
